// File: rtl/decode_pkg.sv
// Shared RV32I decode types and constants for the dual-issue decode stage.
package decode_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Fetch injects this word on flush; it must always decode as an empty slot.
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FmtR,
    FmtI,
    FmtS,
    FmtB,
    FmtU,
    FmtJ
  } imm_fmt_e;

  typedef struct packed {
    logic              valid;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   imm;
    logic              we;
    logic              mem;
  } slot_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] w, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    unique case (fmt)
      FmtI:    imm = {{20{w[31]}}, w[31:20]};
      FmtS:    imm = {{20{w[31]}}, w[31:25], w[11:7]};
      FmtB:    imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FmtU:    imm = {w[31:12], 12'b0};
      FmtJ:    imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32_slot_decoder.sv
// Combinational RV32I decoder: one instruction word into issue-slot fields.
module rv32_slot_decoder
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output slot_t           slot_o,
  output logic            uses_rs2_o
);

  imm_fmt_e fmt;
  logic     known;
  logic     writes_rd;
  logic     uses_rs2;

  always_comb begin
    fmt       = FmtR;
    known     = 1'b1;
    writes_rd = 1'b0;
    uses_rs2  = 1'b0;
    unique case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt       = FmtU;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        fmt       = FmtJ;
        writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        fmt       = FmtI;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        fmt      = FmtB;
        uses_rs2 = 1'b1;
      end
      OPC_STORE: begin
        fmt      = FmtS;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        fmt       = FmtR;
        writes_rd = 1'b1;
        uses_rs2  = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    slot_o     = '0;
    uses_rs2_o = 1'b0;
    if (known && (instr_i != NOP_WORD)) begin
      slot_o.valid    = 1'b1;
      slot_o.opcode   = instr_i[6:0];
      slot_o.funct3   = instr_i[14:12];
      slot_o.funct7b5 = instr_i[30];
      slot_o.rd       = instr_i[11:7];
      slot_o.rs1      = instr_i[19:15];
      slot_o.rs2      = instr_i[24:20];
      slot_o.imm      = gen_imm(instr_i, fmt);
      slot_o.we       = writes_rd && (instr_i[11:7] != '0);
      slot_o.mem      = (instr_i[6:0] == OPC_LOAD) || (instr_i[6:0] == OPC_STORE);
      uses_rs2_o      = uses_rs2;
    end
  end

endmodule

// File: rtl/dual_decode_unit.sv
// Dual-issue decode stage: decodes an instruction pair, splits it on intra-pair hazards.
// Optional DECODE_PERF_CNT_EN adds split and bubble performance counters.
module dual_decode_unit
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              stall_in_i,
  input  logic [XLEN-1:0]   instr1_i,
  input  logic [XLEN-1:0]   instr2_i,
  output logic              stall_out_o,
  output logic              s0_valid_o,
  output logic [6:0]        s0_opcode_o,
  output logic [2:0]        s0_funct3_o,
  output logic              s0_funct7b5_o,
  output logic [REG_AW-1:0] s0_rd_o,
  output logic [REG_AW-1:0] s0_rs1_o,
  output logic [REG_AW-1:0] s0_rs2_o,
  output logic [XLEN-1:0]   s0_imm_o,
  output logic              s0_we_o,
  output logic              s0_mem_o,
  output logic              s1_valid_o,
  output logic [6:0]        s1_opcode_o,
  output logic [2:0]        s1_funct3_o,
  output logic              s1_funct7b5_o,
  output logic [REG_AW-1:0] s1_rd_o,
  output logic [REG_AW-1:0] s1_rs1_o,
  output logic [REG_AW-1:0] s1_rs2_o,
  output logic [XLEN-1:0]   s1_imm_o,
  output logic              s1_we_o,
  output logic              s1_mem_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_split_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o
`endif
);

  typedef enum logic [0:0] {StPair, StSplit} state_e;

  state_e          state_q;
  logic [XLEN-1:0] hold_q;
  slot_t           slot0_q, slot1_q;

  slot_t d1, d2, dh;
  logic  u1, u2, uh;
  logic  dep, structural, split;

  rv32_slot_decoder u_dec1 (.instr_i(instr1_i), .slot_o(d1), .uses_rs2_o(u1));
  rv32_slot_decoder u_dec2 (.instr_i(instr2_i), .slot_o(d2), .uses_rs2_o(u2));
  rv32_slot_decoder u_dech (.instr_i(hold_q),   .slot_o(dh), .uses_rs2_o(uh));

  // Only the younger word's rs2 usage matters for the RAW check.
  logic unused_uses_rs2;
  assign unused_uses_rs2 = u1 ^ uh;

  assign dep        = d1.we && ((d1.rd == d2.rs1) || ((d1.rd == d2.rs2) && u2));
  assign structural = d1.mem && d2.mem;
  assign split      = d1.valid && d2.valid && (dep || structural);

  assign stall_out_o = !flush_i && (stall_in_i || ((state_q == StPair) && split));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StPair;
      hold_q  <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (flush_i) begin
      state_q <= StPair;
      hold_q  <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (!stall_in_i) begin
      unique case (state_q)
        StPair: begin
          slot0_q <= d1;
          if (split) begin
            slot1_q <= '0;
            hold_q  <= instr2_i;
            state_q <= StSplit;
          end else begin
            slot1_q <= d2;
          end
        end
        StSplit: begin
          slot0_q <= '0;
          slot1_q <= dh;
          hold_q  <= '0;
          state_q <= StPair;
        end
        default: state_q <= StPair;
      endcase
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic issue_none;

  // Both slots about to be written empty on this edge.
  always_comb begin
    issue_none = 1'b1;
    if (!flush_i) begin
      if (state_q == StSplit) begin
        issue_none = !dh.valid;
      end else begin
        issue_none = !d1.valid && (split || !d2.valid);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_split_cnt_o  <= '0;
      perf_bubble_cnt_o <= '0;
    end else if (!stall_in_i) begin
      if (!flush_i && (state_q == StPair) && split) begin
        perf_split_cnt_o <= perf_split_cnt_o + 32'd1;
      end
      if (issue_none) begin
        perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

  assign s0_valid_o    = slot0_q.valid;
  assign s0_opcode_o   = slot0_q.opcode;
  assign s0_funct3_o   = slot0_q.funct3;
  assign s0_funct7b5_o = slot0_q.funct7b5;
  assign s0_rd_o       = slot0_q.rd;
  assign s0_rs1_o      = slot0_q.rs1;
  assign s0_rs2_o      = slot0_q.rs2;
  assign s0_imm_o      = slot0_q.imm;
  assign s0_we_o       = slot0_q.we;
  assign s0_mem_o      = slot0_q.mem;

  assign s1_valid_o    = slot1_q.valid;
  assign s1_opcode_o   = slot1_q.opcode;
  assign s1_funct3_o   = slot1_q.funct3;
  assign s1_funct7b5_o = slot1_q.funct7b5;
  assign s1_rd_o       = slot1_q.rd;
  assign s1_rs1_o      = slot1_q.rs1;
  assign s1_rs2_o      = slot1_q.rs2;
  assign s1_imm_o      = slot1_q.imm;
  assign s1_we_o       = slot1_q.we;
  assign s1_mem_o      = slot1_q.mem;

endmodule
